uart_rx_frame: RTL and testbench

Serial receive engine for the UART SoC: the receive end of the serial link whose transmit side the interface block drives. It oversamples `rx` at 16x the baud rate, deframes 5–8 data bits with optional parity and stop checking, and presents each byte with status flags and a level interrupt. Line format follows 16550 LCR semantics. The baud divisor is `{dlh,dll}`, the same as the transmitter.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_rx_frame.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-control bit positions,
// receive FSM states and the status-flag bundle.
package uart_pkg;

  localparam int LCR_WLS  = 0;
  localparam int LCR_STB  = 2;
  localparam int LCR_PEN  = 3;
  localparam int LCR_EPS  = 4;
  localparam int LCR_SP   = 5;
  localparam int OVS_HALF = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK
  } rx_state_e;

  typedef struct packed {
    logic perr;
    logic ferr;
    logic brk;
  } rx_flags_t;

  // Expected parity bit given the XOR of the data bits.
  function automatic logic exp_par(
    input logic acc,
    input logic eps,
    input logic sp
  );
    return sp ? ~eps : (acc ^ ~eps);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Divisor-to-16x tick generator, shared with the transmitter.
// A divisor of 0 behaves as 1; reload restarts the period.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] dm1;

  assign dm1  = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign tick = !reload && (cnt >= dm1);

  // Free-running period counter, cleared on reload or wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload || cnt >= dm1) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive engine: 16x oversampled deframer with
// parity/stop checking, break detect and a level interrupt.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ideal_rx,
  input  logic       rx,
  input  logic [7:0] lcr,
  input  logic [7:0] dll,
  input  logic [7:0] dlh,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       rx_int,
  output logic       overrun
);

  rx_state_e              state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   tick;
  logic [3:0]             tcnt;
  logic [2:0]             bcnt;
  logic [7:0]             sh;
  logic                   par;
  logic                   ones;
  logic                   perr_r;
  rx_flags_t              flags;

  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       sp;
  logic [2:0] nlast;
  logic [1:0] shamt;
  logic       bit_end;
  logic       unused_ok;

  assign wls       = lcr[LCR_WLS +: 2];
  assign pen       = lcr[LCR_PEN];
  assign eps       = lcr[LCR_EPS];
  assign sp        = lcr[LCR_SP];
  assign nlast     = 3'd4 + {1'b0, wls};
  assign shamt     = 2'd3 - wls;
  assign rx_s      = sync[SYNC_STAGES-1];
  assign bit_end   = tick && (tcnt == 4'(OVS - 1));
  assign unused_ok = ^{lcr[7:6], lcr[LCR_STB]};

  assign parity_err = flags.perr;
  assign frame_err  = flags.ferr;
  assign break_det  = flags.brk;

  uart_baud_gen u_baud (
    .clk    (clk),
    .rst    (rst),
    .reload (state == RX_IDLE),
    .div    ({dlh, dll}),
    .tick   (tick)
  );

  // Bring the asynchronous line into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
    end
  end

  // Frame FSM, shift register, parity and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RX_IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      sh       <= '0;
      par      <= 1'b0;
      ones     <= 1'b0;
      perr_r   <= 1'b0;
      flags    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_int   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_ack) begin
        rx_int  <= 1'b0;
        overrun <= 1'b0;
      end
      if (ideal_rx) begin
        state <= RX_IDLE;
      end else begin
        unique case (state)
          RX_IDLE: begin
            if (!rx_s) begin
              state  <= RX_START;
              tcnt   <= '0;
              bcnt   <= '0;
              par    <= 1'b0;
              ones   <= 1'b0;
              perr_r <= 1'b0;
            end
          end
          RX_START: begin
            if (tick) begin
              tcnt <= tcnt + 4'd1;
              if (tcnt == 4'(OVS_HALF - 1)) begin
                tcnt  <= '0;
                state <= rx_s ? RX_IDLE : RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (tick) begin
              tcnt <= tcnt + 4'd1;
            end
            if (bit_end) begin
              sh   <= {rx_s, sh[7:1]};
              par  <= par ^ rx_s;
              ones <= ones | rx_s;
              bcnt <= bcnt + 3'd1;
              if (bcnt == nlast) begin
                state <= pen ? RX_PARITY : RX_STOP;
              end
            end
          end
          RX_PARITY: begin
            if (tick) begin
              tcnt <= tcnt + 4'd1;
            end
            if (bit_end) begin
              perr_r <= rx_s != exp_par(par, eps, sp);
              ones   <= ones | rx_s;
              state  <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (tick) begin
              tcnt <= tcnt + 4'd1;
            end
            if (bit_end) begin
              rx_valid   <= 1'b1;
              rx_data    <= sh >> shamt;
              flags.perr <= perr_r;
              flags.ferr <= ~rx_s;
              flags.brk  <= ~(ones | rx_s);
              rx_int     <= 1'b1;
              if (rx_int && !rx_ack) begin
                overrun <= 1'b1;
              end
              state <= rx_s ? RX_IDLE : RX_BRK;
            end
          end
          RX_BRK: begin
            if (rx_s) begin
              state <= RX_IDLE;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at divisor 2:
// 32 clocks (320 time units) per serial bit.
module tb_uart_rx_frame;

  localparam int BIT = 320;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ideal_rx = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] lcr = 8'h03;
  logic [7:0] dll = 8'd2;
  logic [7:0] dlh = 8'd0;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       rx_int;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int v0;

  uart_rx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .ideal_rx   (ideal_rx),
    .rx         (rx),
    .lcr        (lcr),
    .dll        (dll),
    .dlh        (dlh),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .rx_int     (rx_int),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) vcnt <= vcnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    #BIT;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n,
                            input logic pen, input logic pb,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (pen) send_bit(pb);
    send_bit(stop);
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #23;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_brk", break_det, 1'b0);
    chk("rst_int", rx_int, 1'b0);
    chk("rst_ovr", overrun, 1'b0);

    // 8N1 0xA5
    v0 = vcnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    #200;
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_cnt", vcnt - v0, 1);
    chk("a5_perr", parity_err, 1'b0);
    chk("a5_ferr", frame_err, 1'b0);
    chk("a5_brk", break_det, 1'b0);
    chk("a5_int", rx_int, 1'b1);
    ack();
    chk("a5_ack", rx_int, 1'b0);

    // 8O1 0x5A: four ones, so parity bit must be 1
    lcr = 8'h0B;
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b1);
    #200;
    chk("par0_data", rx_data, 8'h5A);
    chk("par0_err", parity_err, 1'b1);
    ack();
    send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1);
    #200;
    chk("par1_err", parity_err, 1'b0);
    chk("par1_ferr", frame_err, 1'b0);
    ack();

    // 5N1 0x1F with a low stop bit, line then held low
    lcr = 8'h00;
    v0 = vcnt;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0);
    chk("fe_data", rx_data, 8'h1F);
    chk("fe_ferr", frame_err, 1'b1);
    chk("fe_brk", break_det, 1'b0);
    #(2 * BIT);
    chk("fe_hold", vcnt - v0, 1);
    rx = 1'b1;
    #(2 * BIT);
    chk("fe_release", vcnt - v0, 1);
    ack();

    // False start: 4 ticks low
    v0 = vcnt;
    rx = 1'b0;
    #80;
    rx = 1'b1;
    #(3 * BIT);
    chk("false_cnt", vcnt - v0, 0);

    // Break: low for a whole 5N1 frame
    rx = 1'b0;
    #(7 * BIT);
    rx = 1'b1;
    #(2 * BIT);
    chk("brk_cnt", vcnt - v0, 1);
    chk("brk_det", break_det, 1'b1);
    chk("brk_ferr", frame_err, 1'b1);
    chk("brk_data", rx_data, 8'h00);
    ack();

    // Overrun: two frames without ack
    lcr = 8'h03;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    #100;
    chk("ov1_ovr", overrun, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    #200;
    chk("ov2_data", rx_data, 8'h22);
    chk("ov2_ovr", overrun, 1'b1);
    chk("ov2_int", rx_int, 1'b1);
    ack();
    chk("ov_ack_int", rx_int, 1'b0);
    chk("ov_ack_ovr", overrun, 1'b0);

    // Reset during the 4th data bit
    v0 = vcnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    #(BIT / 2);
    rst = 1'b1;
    rx = 1'b1;
    #20;
    rst = 1'b0;
    #(2 * BIT);
    chk("rab_cnt", vcnt - v0, 0);
    chk("rab_data", rx_data, 8'h00);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    #200;
    chk("rab_next", rx_data, 8'h3C);
    chk("rab_ncnt", vcnt - v0, 1);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    #200;
    chk("d81_data", rx_data, 8'h81);
    ack();

    // ideal_rx during the 4th data bit
    v0 = vcnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    #(BIT / 2);
    ideal_rx = 1'b1;
    #100;
    rx = 1'b1;
    #100;
    ideal_rx = 1'b0;
    #(2 * BIT);
    chk("iab_cnt", vcnt - v0, 0);
    chk("iab_data", rx_data, 8'h81);
    chk("iab_int", rx_int, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    #200;
    chk("iab_next", rx_data, 8'h3C);
    chk("iab_ncnt", vcnt - v0, 1);
    chk("iab_ferr", frame_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
